hpm_counter_bank: RTL and testbench
===================================

// Module: hpm_counter_bank
// PURPOSE
// - Parametrised hardware performance-monitor counter bank: NUM_COUNTERS counters (mhpmcounter3..), each CNT_WIDTH wide.
// - Each counter has its own event selector (mhpmevent3..).
// - Counts multi-per-cycle events (e.g. several commit ports) via per-event increment vectors.
// - Sits beside csr_regfile; the CSR file forwards the 12-bit CSR address, data and write enable, and muxes data_o into its read path.
// PARAMETERS
// - NUM_COUNTERS  6   number of counters, 1..29 (counter k maps to CSR index k+3)
// - CNT_WIDTH     64  implemented counter width, 1..64; upper bits read 0, writes to them ignored
// - NUM_EVENTS    32  number of event inputs; selector 0 is hard-wired to "no event"
// - INC_W         2   width of each per-cycle event increment
// - XLEN          64  CSR data width, 32 or 64
// PORTS
// - clk_i             in   1                      clock
// - rst_ni            in   1                      asynchronous reset, active-low
// - debug_mode_i      in   1                      core in debug mode: counting frozen
// - addr_i            in   12                     CSR address
// - we_i              in   1                      CSR write strobe
// - data_i            in   XLEN                   CSR write data
// - data_o            out  XLEN                   CSR read data, combinational from addr_i
// - access_ex_o       out  1                      illegal access for this address/XLEN, combinational
// - event_inc_i       in   NUM_EVENTS x INC_W     per-event increment this cycle
// - mcountinhibit_i   in   32                     bit k+3 inhibits counter k
// - ovf_o             out  NUM_COUNTERS           per-counter OF flag
// - ovf_irq_o         out  1                      level overflow interrupt request (LCOFI)
// BEHAVIOUR
// - Reset: all counters, selectors, OF flags and the pipeline register go to 0. Outputs at reset: data_o=0, access_ex_o=0, ovf_o=0, ovf_irq_o=0.
// - Stage 1 (registered): inc_q[k] = event_inc_i[sel_q[k]].
//   - inc_q[k] is forced to 0 when any of these hold: sel_q[k]==0, sel_q[k]>=NUM_EVENTS, debug_mode_i=1, mcountinhibit_i[k+3]=1.
// - Stage 2: cnt_q[k] <= cnt_q[k] + inc_q[k], modulo 2^CNT_WIDTH.
//   - An event at cycle N is first readable at cycle N+2.
// - Overflow: a carry out of bit CNT_WIDTH-1 in stage 2 sets OF[k]. OF is sticky until software clears it.
// - CSR map (k = addr - base + 1, valid when 1 <= k <= NUM_COUNTERS):
//   - 0xB03+: counter, low XLEN bits; R/W.
//   - 0xB83+: counter[63:32]; R/W when XLEN=32, access_ex_o=1 when XLEN=64.
//   - 0x323+: mhpmevent; bits[4:0]=selector, bit XLEN-1=OF, other bits read 0.
//   - 0xC03+ / 0xC83+: read-only user shadows; a write raises access_ex_o and has no effect.
// - Addresses inside a window but beyond NUM_COUNTERS: read 0, writes ignored, no exception.
// - Write to counter k in cycle N:
//   - cnt_q[k] takes data_i at N+1.
//   - The inc_q[k] due in cycle N is discarded.
//   - Other counters keep counting normally.
// - Write to mhpmevent k in cycle N:
//   - New selector is used by stage 1 from cycle N+1.
//   - The in-flight inc_q[k] is still applied.
// - Simultaneous hardware overflow and software write of OF=0 in the same cycle: the hardware set wins, OF=1.
// - Reset asserted mid-count: all state clears immediately; nothing in flight survives.
// CONFIGURATION
// - Macro HPM_OVF_IRQ_EN defined:
//   - OF implemented as above; ovf_o = OF.
//   - ovf_irq_o = OR over k of (OF[k] & ~mcountinhibit_i[k+3]), registered (one cycle after OF sets).
// - Macro not defined:
//   - No OF storage: OF reads 0, writes to it ignored.
//   - ovf_o and ovf_irq_o tied 0; counters wrap silently.
// TESTING
// - Basic count: sel[1]=5, event_inc_i[5]=2 for 10 cycles -> mhpmcounter4 reads 20 at cycle 12; reads 0 at cycles 0-1.
// - Inhibit/debug: mcountinhibit_i[3]=1, or debug_mode_i=1, with an active event -> mhpmcounter3 unchanged; other counters still increment.
// - Write priority: counter 3 counting +1/cycle, write 0x100 at cycle N -> reads 0x100 at N+1, 0x101 at N+2; counter 4 unaffected.
// - Wrap/overflow (CNT_WIDTH=8, macro on): write 0xFE, inc 1/cycle -> 0xFF, then 0x00 with OF=1; ovf_irq_o=1 next cycle.
//   - Then write mhpmevent3 with OF=0 -> ovf_irq_o=0.
// - Access rules (XLEN=64):
//   - Read 0xB83 -> access_ex_o=1.
//   - Write 0xC03 -> access_ex_o=1, counter unchanged.
//   - Read 0xB1F with NUM_COUNTERS=6 -> data_o=0, access_ex_o=0.
// - Selector edge: sel=0, or sel>=NUM_EVENTS, with all event_inc_i maxed -> counter stays 0; with macro off, OF bit always reads 0.

Source files
------------

// File: rtl/hpm_counter_bank.sv
// rtl/hpm_counter_bank.sv - HPM counter bank with per-counter event selectors; HPM_OVF_IRQ_EN adds OF flags and LCOFI
// Two-stage pipeline: selected increment registered, then accumulated into the counter.
module hpm_counter_bank #(
  parameter int NUM_COUNTERS = 6,
  parameter int CNT_WIDTH    = 64,
  parameter int NUM_EVENTS   = 32,
  parameter int INC_W        = 2,
  parameter int XLEN         = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             debug_mode_i,
  input  logic [11:0]                      addr_i,
  input  logic                             we_i,
  input  logic [XLEN-1:0]                  data_i,
  output logic [XLEN-1:0]                  data_o,
  output logic                             access_ex_o,
  input  logic [NUM_EVENTS-1:0][INC_W-1:0] event_inc_i,
  input  logic [31:0]                      mcountinhibit_i,
  output logic [NUM_COUNTERS-1:0]          ovf_o,
  output logic                             ovf_irq_o
);

  logic [CNT_WIDTH-1:0]    cnt_q   [NUM_COUNTERS];
  logic [4:0]              sel_q   [NUM_COUNTERS];
  logic [INC_W-1:0]        inc_q   [NUM_COUNTERS];
  logic [CNT_WIDTH:0]      sum     [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] add_en;
  logic [NUM_COUNTERS-1:0] ovf_set;
  logic [NUM_COUNTERS-1:0] of_bits;

  // Every window starts at offset 3 of a 32-entry block; idx is the 0-based counter number.
  logic [4:0] idx;
  logic       idx_ok;
  logic       win_cnt_lo, win_cnt_hi, win_evt, win_sh_lo, win_sh_hi;

  assign idx        = addr_i[4:0] - 5'd3;
  assign idx_ok     = (addr_i[4:0] >= 5'd3) && ({1'b0, idx} < 6'(NUM_COUNTERS));
  assign win_cnt_lo = idx_ok && (addr_i[11:5] == 7'h58);
  assign win_cnt_hi = idx_ok && (addr_i[11:5] == 7'h5C);
  assign win_evt    = idx_ok && (addr_i[11:5] == 7'h19);
  assign win_sh_lo  = idx_ok && (addr_i[11:5] == 7'h60);
  assign win_sh_hi  = idx_ok && (addr_i[11:5] == 7'h64);

  logic [63:0] cnt_rd;
  logic [4:0]  sel_rd;
  logic        of_rd;

  always_comb begin
    cnt_rd = '0;
    sel_rd = '0;
    of_rd  = 1'b0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (idx == 5'(k)) begin
        cnt_rd = 64'(cnt_q[k]);
        sel_rd = sel_q[k];
        of_rd  = of_bits[k];
      end
    end
  end

  always_comb begin
    data_o      = '0;
    access_ex_o = 1'b0;
    if (win_cnt_lo || win_sh_lo) begin
      data_o = cnt_rd[XLEN-1:0];
    end else if (win_cnt_hi || win_sh_hi) begin
      if (XLEN == 32) data_o = XLEN'(cnt_rd[63:32]);
      else            access_ex_o = 1'b1;
    end else if (win_evt) begin
      data_o[4:0]      = sel_rd;
      data_o[XLEN-1]   = of_rd;
    end
    if ((win_sh_lo || win_sh_hi) && we_i) access_ex_o = 1'b1;
  end

  logic        wr_cnt, wr_evt;
  logic [63:0] wr_val;

  assign wr_cnt = we_i && (win_cnt_lo || (win_cnt_hi && (XLEN == 32)));
  assign wr_evt = we_i && win_evt;

  // Merge the written half into the 64-bit view so RV32 high/low writes compose.
  always_comb begin
    wr_val = cnt_rd;
    if (win_cnt_hi)      wr_val[63:32] = data_i[31:0];
    else if (XLEN == 64) wr_val        = 64'(data_i);
    else                 wr_val[31:0]  = data_i[31:0];
  end

  always_comb begin
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      sum[k]     = {1'b0, cnt_q[k]} + (CNT_WIDTH+1)'(inc_q[k]);
      add_en[k]  = !(wr_cnt && (idx == 5'(k)));
      ovf_set[k] = add_en[k] && sum[k][CNT_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
        inc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if ((sel_q[k] == 5'd0) || ({1'b0, sel_q[k]} >= 6'(NUM_EVENTS)) ||
            debug_mode_i || mcountinhibit_i[k+3])
          inc_q[k] <= '0;
        else
          inc_q[k] <= event_inc_i[sel_q[k]];
        // A software write replaces the add, dropping the increment due this cycle.
        if (add_en[k]) cnt_q[k] <= sum[k][CNT_WIDTH-1:0];
        else           cnt_q[k] <= wr_val[CNT_WIDTH-1:0];
        if (wr_evt && (idx == 5'(k))) sel_q[k] <= data_i[4:0];
      end
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] of_q;
  logic                    irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        // Hardware set wins over a same-cycle software clear.
        if (wr_evt && (idx == 5'(k))) of_q[k] <= data_i[XLEN-1] | ovf_set[k];
        else if (ovf_set[k])          of_q[k] <= 1'b1;
      end
      irq_q <= |(of_q & ~mcountinhibit_i[NUM_COUNTERS+2:3]);
    end
  end

  assign of_bits   = of_q;
  assign ovf_o     = of_q;
  assign ovf_irq_o = irq_q;
`else
  assign of_bits   = '0;
  assign ovf_o     = '0;
  assign ovf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb/tb_hpm_counter_bank.sv - scoreboard bench for hpm_counter_bank (default instance and an 8-bit instance)
module tb_hpm_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             debug;
  logic [31:0][1:0] ev;
  logic [31:0]      inhibit;
  logic [11:0]      addr_a, addr_b;
  logic             we_a, we_b;
  logic [63:0]      wdata_a, wdata_b, rdata_a, rdata_b;
  logic             ex_a, ex_b;
  logic [5:0]       ovf_a;
  logic [1:0]       ovf_b;
  logic             irq_a, irq_b;

`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  hpm_counter_bank dut_a (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug),
    .addr_i(addr_a), .we_i(we_a), .data_i(wdata_a), .data_o(rdata_a),
    .access_ex_o(ex_a), .event_inc_i(ev), .mcountinhibit_i(inhibit),
    .ovf_o(ovf_a), .ovf_irq_o(irq_a)
  );

  hpm_counter_bank #(.NUM_COUNTERS(2), .CNT_WIDTH(8), .NUM_EVENTS(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug),
    .addr_i(addr_b), .we_i(we_b), .data_i(wdata_b), .data_o(rdata_b),
    .access_ex_o(ex_b), .event_inc_i(ev[7:0]), .mcountinhibit_i(inhibit),
    .ovf_o(ovf_b), .ovf_irq_o(irq_b)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input logic [11:0] a);
    addr_a = a; we_a = 1'b0; #1;
    observe(rdata_a);
  endtask

  task automatic rd_b(input logic [11:0] a);
    addr_b = a; we_b = 1'b0; #1;
    observe(rdata_b);
  endtask

  task automatic wr_a(input logic [11:0] a, input logic [63:0] d);
    addr_a = a; wdata_a = d; we_a = 1'b1;
    tick();
    we_a = 1'b0;
  endtask

  task automatic wr_b(input logic [11:0] a, input logic [63:0] d);
    addr_b = a; wdata_b = d; we_b = 1'b1;
    tick();
    we_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; debug = 1'b0; ev = '0; inhibit = '0;
    addr_a = '0; addr_b = '0; we_a = 1'b0; we_b = 1'b0; wdata_a = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_val("reset_cnt3", 64'd0); rd_a(12'hB03);
    expect_val("reset_ex", 64'd0);   observe(64'(ex_a));
    expect_val("reset_ovf", 64'd0);  observe(64'(ovf_a));
    expect_val("reset_irq", 64'd0);  observe(64'(irq_a));
    rst_n = 1'b1;
    tick();

    // Basic count: counter 4 on event 5, +2 for cycles 0..9
    wr_a(12'h324, 64'd5);
    ev[5] = 2'd2;
    expect_val("basic_cyc0", 64'd0); rd_a(12'hB04);
    tick();
    expect_val("basic_cyc1", 64'd0); rd_a(12'hB04);
    repeat (9) tick();
    ev[5] = 2'd0;
    repeat (2) tick();
    expect_val("basic_cyc12", 64'd20); rd_a(12'hB04);
    expect_val("sel0_cnt3", 64'd0);    rd_a(12'hB03);
    expect_val("evt4_read", 64'd5);    rd_a(12'h324);

    // Inhibit then debug freeze
    wr_a(12'h323, 64'd7);
    wr_a(12'h324, 64'd7);
    inhibit[3] = 1'b1; ev[7] = 2'd1;
    repeat (5) tick();
    ev[7] = 2'd0; inhibit = '0;
    repeat (2) tick();
    expect_val("inhibit_cnt3", 64'd0); rd_a(12'hB03);
    expect_val("inhibit_cnt4", 64'd25); rd_a(12'hB04);
    debug = 1'b1; ev[7] = 2'd1;
    repeat (3) tick();
    ev[7] = 2'd0; debug = 1'b0;
    repeat (2) tick();
    expect_val("debug_cnt3", 64'd0);  rd_a(12'hB03);
    expect_val("debug_cnt4", 64'd25); rd_a(12'hB04);

    // Write priority while counting
    ev[7] = 2'd1;
    repeat (3) tick();
    wr_a(12'hB03, 64'h100);
    expect_val("wr_n1", 64'h100); rd_a(12'hB03);
    tick();
    expect_val("wr_n2", 64'h101); rd_a(12'hB03);
    expect_val("wr_other", 64'd29); rd_a(12'hB04);
    ev[7] = 2'd0;
    repeat (2) tick();
    expect_val("wr_settle3", 64'h102); rd_a(12'hB03);
    expect_val("wr_settle4", 64'd30);  rd_a(12'hB04);

    // Access rules
    addr_a = 12'hB83; #1;
    expect_val("ex_b83", 64'd1); observe(64'(ex_a));
    addr_a = 12'hC83; #1;
    expect_val("ex_c83", 64'd1); observe(64'(ex_a));
    addr_a = 12'hC03; wdata_a = 64'hDEAD; we_a = 1'b1; #1;
    expect_val("ex_wr_c03", 64'd1); observe(64'(ex_a));
    tick();
    we_a = 1'b0;
    expect_val("c03_nowrite", 64'h102); rd_a(12'hB03);
    expect_val("c03_shadow", 64'h102);  rd_a(12'hC03);
    expect_val("b1f_data", 64'd0); rd_a(12'hB1F);
    expect_val("b1f_ex", 64'd0);   observe(64'(ex_a));
    wr_a(12'hB09, 64'h55);
    expect_val("b09_ignored", 64'd0); rd_a(12'hB09);

    // Selector edges with every event maxed
    wr_b(12'h324, 64'd9);
    ev = '1;
    repeat (4) tick();
    ev = '0;
    repeat (2) tick();
    expect_val("sel0_cnt5", 64'd0);  rd_a(12'hB05);
    expect_val("sel0_evt5", 64'd0);  rd_a(12'h325);
    expect_val("selhi_cnt", 64'd0);  rd_b(12'hB04);
    expect_val("selhi_evt", 64'd9);  rd_b(12'h324);
    expect_val("a_ovf_none", 64'd0); observe(64'(ovf_a));

    // Wrap / overflow on the 8-bit instance
    wr_b(12'h323, 64'd1);
    wr_b(12'hB03, 64'hFE);
    ev[1] = 2'd1;
    tick();
    expect_val("wrap_fe", 64'hFE); rd_b(12'hB03);
    tick();
    expect_val("wrap_ff", 64'hFF); rd_b(12'hB03);
    expect_val("wrap_ovf_pre", 64'd0); observe(64'(ovf_b));
    tick();
    expect_val("wrap_00", 64'h00); rd_b(12'hB03);
    expect_val("wrap_ovf", OVF ? 64'd1 : 64'd0); observe(64'(ovf_b));
    expect_val("wrap_of_bit", OVF ? 64'h8000_0000_0000_0001 : 64'd1); rd_b(12'h323);
    expect_val("wrap_irq_same", 64'd0); observe(64'(irq_b));
    tick();
    expect_val("wrap_irq", 64'(OVF)); observe(64'(irq_b));
    ev[1] = 2'd0;
    wr_b(12'h323, 64'd1);
    expect_val("clr_ovf", 64'd0); observe(64'(ovf_b));
    expect_val("clr_irq_lag", 64'(OVF)); observe(64'(irq_b));
    tick();
    expect_val("clr_irq", 64'd0); observe(64'(irq_b));
    expect_val("wrap_final", 64'd2); rd_b(12'hB03);

    // Asynchronous reset mid-count
    ev[7] = 2'd1;
    repeat (3) tick();
    rst_n = 1'b0; #1;
    expect_val("rst_mid_cnt", 64'd0); rd_a(12'hB03);
    expect_val("rst_mid_sel", 64'd0); rd_a(12'h323);
    ev = '0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    expect_val("rst_after", 64'd0); rd_a(12'hB04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
